niosii_buts_debounce: RTL



---
 rtl/niosii_buts_debounce.sv | 77 +++++++
 1 files changed

// File: rtl/niosii_buts_debounce.sv
// Button conditioning: polarity fix, two-flop synchroniser, per-bit debounce counter,
// and single-cycle press/release pulses feeding the button PIO in_port.
module niosii_buts_debounce #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] level_out,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse,
    output logic             any_press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] pol_in;
    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] stable;
    logic [CNT_W-1:0] cnt     [WIDTH];
    logic [CNT_W-1:0] cnt_nxt [WIDTH];
    logic [WIDTH-1:0] stable_nxt;
    logic [WIDTH-1:0] press_nxt;
    logic [WIDTH-1:0] release_nxt;

    // Internally 1 = pressed regardless of pin polarity.
    assign pol_in    = raw_in ^ {WIDTH{ACTIVE_LOW}};
    assign level_out = stable;

    // Per-bit debounce: a differing level must be seen CNT_LAST+1 times in a row.
    always_comb begin
        stable_nxt  = stable;
        press_nxt   = '0;
        release_nxt = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_nxt[i] = '0;
            if (sync2[i] != stable[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    stable_nxt[i]  = ~stable[i];
                    press_nxt[i]   = ~stable[i];
                    release_nxt[i] = stable[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1         <= '0;
            sync2         <= '0;
            stable        <= '0;
            press_pulse   <= '0;
            release_pulse <= '0;
            any_press     <= 1'b0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1         <= pol_in;
            sync2         <= sync1;
            stable        <= stable_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
            any_press     <= |press_nxt;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

endmodule
